sopc_pio_pulse_out: RTL and testbench

- Avalon-MM slave output PIO for the SOPC system.
- The CPU writes a level register that drives out_port.
- The CPU can also trigger a hardware-timed one-shot pulse: selected bits are inverted for a programmed number of clock cycles, then revert with no further software action.
- Sits beside the input PIOs on the system interconnect and drives board-level control lines.

---
 rtl/sopc_pio_pulse_out.sv | 118 +++++++++++
 tb/tb_sopc_pio_pulse_out.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sopc_pio_pulse_out.sv
// Avalon-MM output PIO with a hardware-timed one-shot inversion pulse.
// Optional pulse-done interrupt (irq port, STATUS bit2 enable) under SOPC_PIO_PULSE_IRQ_EN.
module sopc_pio_pulse_out #(
    parameter int               WIDTH       = 8,
    parameter int               CNT_W       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
`ifdef SOPC_PIO_PULSE_IRQ_EN
    output logic             irq,
`endif
    output logic [WIDTH-1:0] out_port
);

    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   data_reg;
    logic [WIDTH-1:0]   mask_reg;
    logic [CNT_W-1:0]   len_reg;
    logic [CNT_W-1:0]   cnt;
    logic               done;
    logic               irq_en;
    logic               wr;
    logic               busy;
    logic [WIDTH-1:0]   trig_mask;
    logic [31:0]        rd_mux;
    logic               unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign busy         = (state == PULSE);
    assign trig_mask    = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            data_reg <= RESET_VALUE;
            len_reg  <= '0;
            mask_reg <= '0;
            cnt      <= '0;
            done     <= 1'b0;
            irq_en   <= 1'b0;
        end else begin
            if (wr && address == 2'd0)
                data_reg <= writedata[WIDTH-1:0];
            if (wr && address == 2'd1)
                len_reg <= writedata[CNT_W-1:0];
            if (wr && address == 2'd3) begin
                if (writedata[1])
                    done <= 1'b0;
`ifdef SOPC_PIO_PULSE_IRQ_EN
                irq_en <= writedata[2];
`endif
            end

            // The completion assignment to done comes last so it wins over a same-edge clear.
            case (state)
                IDLE: begin
                    if (wr && address == 2'd2 && trig_mask != '0 && len_reg != '0) begin
                        mask_reg <= trig_mask;
                        cnt      <= len_reg;
                        state    <= PULSE;
                    end
                end
                PULSE: begin
                    if (cnt == CNT_W'(1)) begin
                        mask_reg <= '0;
                        cnt      <= '0;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0: rd_mux[WIDTH-1:0] = data_reg;
            2'd1: rd_mux[CNT_W-1:0] = len_reg;
            2'd2: rd_mux[WIDTH-1:0] = mask_reg;
            2'd3: begin
                rd_mux[0] = busy;
                rd_mux[1] = done;
                rd_mux[2] = irq_en;
            end
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            readdata <= '0;
        else
            readdata <= rd_mux;
    end

    assign out_port = data_reg ^ mask_reg;

`ifdef SOPC_PIO_PULSE_IRQ_EN
    assign irq = done & irq_en;
`endif

endmodule

// File: tb/tb_sopc_pio_pulse_out.sv
// Self-checking bench for sopc_pio_pulse_out (RESET_VALUE = 8'h5A), with a cycle-indexed pulse model.
// The irq scenario runs only when SOPC_PIO_PULSE_IRQ_EN is defined.
module tb_sopc_pio_pulse_out;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
`ifdef SOPC_PIO_PULSE_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: a pulse is described by its trigger edge and length; everything is derived from cycle numbers.
    logic [7:0]  m_data;
    logic [15:0] m_len;
    logic [7:0]  m_mask;
    logic        have_pulse;
    int          m_start;
    int          m_end;
    int          m_clr;
    logic        m_sticky;
    logic        m_irq_en;

    sopc_pio_pulse_out #(
        .WIDTH(8),
        .CNT_W(16),
        .RESET_VALUE(8'h5A)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
`ifdef SOPC_PIO_PULSE_IRQ_EN
        .irq(irq),
`endif
        .out_port(out_port)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic busy_at(int c);
        return have_pulse && c >= m_start && c < m_end;
    endfunction

    function automatic logic done_at(int c);
        if (have_pulse && c >= m_end)
            return !(m_clr > m_end && m_clr <= c);
        return m_sticky;
    endfunction

    function automatic logic [7:0] out_at(int c);
        return m_data ^ (busy_at(c) ? m_mask : 8'h00);
    endfunction

    function automatic logic [31:0] status_at(int c);
        return {29'd0, m_irq_en, done_at(c), busy_at(c)};
    endfunction

    task automatic model_reset();
        m_data     = 8'h5A;
        m_len      = 16'd0;
        m_mask     = 8'h00;
        have_pulse = 1'b0;
        m_start    = 0;
        m_end      = 0;
        m_clr      = -1;
        m_sticky   = 1'b0;
        m_irq_en   = 1'b0;
    endtask

    // Applies a write sampled at edge x; the model state reflects values before that edge.
    task automatic model_write(input logic [1:0] a, input logic [31:0] d, input int x);
        case (a)
            2'd0: m_data = d[7:0];
            2'd1: m_len = d[15:0];
            2'd2: begin
                if (!busy_at(x - 1) && d[7:0] != 8'h00 && m_len != 16'd0) begin
                    m_sticky   = done_at(x - 1);
                    have_pulse = 1'b1;
                    m_start    = x;
                    m_end      = x + int'(m_len);
                    m_mask     = d[7:0];
                    m_clr      = -1;
                end
            end
            default: begin
                if (d[1]) begin
                    if (have_pulse && x >= m_end) m_clr = x;
                    else m_sticky = 1'b0;
                end
`ifdef SOPC_PIO_PULSE_IRQ_EN
                m_irq_en = d[2];
`endif
            end
        endcase
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        logic [7:0] exp_out;
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        model_write(a, d, cyc + 1);
        @(posedge clk);
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        exp_out    = out_at(cyc);
        checks++;
        if (out_port !== exp_out) begin
            errors++;
            $display("FAIL out_after_write[a=%0d]: got %h expected %h (cyc %0d)", a, out_port, exp_out, cyc);
        end
`ifdef SOPC_PIO_PULSE_IRQ_EN
        checks++;
        if (irq !== (done_at(cyc) & m_irq_en)) begin
            errors++;
            $display("FAIL irq_after_write: got %b expected %b", irq, done_at(cyc) & m_irq_en);
        end
`endif
    endtask

    // One idle cycle reading STATUS: checks the registered read and out_port against the model.
    task automatic idle_check();
        logic [31:0] exp_st;
        logic [7:0]  exp_out;
        address    = 2'd3;
        chipselect = 1'b0;
        write_n    = 1'b1;
        exp_st     = status_at(cyc);
        @(posedge clk);
        @(negedge clk);
        exp_out = out_at(cyc);
        checks++;
        if (readdata !== exp_st) begin
            errors++;
            $display("FAIL status_read: got %h expected %h (cyc %0d)", readdata, exp_st, cyc);
        end
        checks++;
        if (out_port !== exp_out) begin
            errors++;
            $display("FAIL out_port: got %h expected %h (cyc %0d)", out_port, exp_out, cyc);
        end
`ifdef SOPC_PIO_PULSE_IRQ_EN
        checks++;
        if (irq !== (done_at(cyc) & m_irq_en)) begin
            errors++;
            $display("FAIL irq: got %b expected %b", irq, done_at(cyc) & m_irq_en);
        end
`endif
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b0;
        write_n    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d = readdata;
    endtask

    task automatic hold_reset(input int n);
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (out_port !== 8'h5A || readdata !== 32'h0) begin
                errors++;
                $display("FAIL in_reset: out_port %h readdata %h expected 5a / 0", out_port, readdata);
            end
        end
        model_reset();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        @(negedge clk);
        hold_reset(3);
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h0 || out_port !== 8'h5A) begin
            errors++;
            $display("FAIL reset_state: status %h out_port %h expected 0 / 5a", rd, out_port);
        end
        bus_read(2'd0, rd);
        checks++;
        if (rd !== 32'h5A) begin
            errors++;
            $display("FAIL reset_data_read: got %h expected 0000005a", rd);
        end
    endtask

    task automatic test_data();
        logic [31:0] rd;
        bus_write(2'd0, 32'h0000_000F);
        checks++;
        if (out_port !== 8'h0F) begin
            errors++;
            $display("FAIL data_out: got %h expected 0f", out_port);
        end
        bus_read(2'd0, rd);
        checks++;
        if (rd !== 32'h0000_000F) begin
            errors++;
            $display("FAIL data_read: got %h expected 0000000f", rd);
        end
    endtask

    task automatic test_pulse();
        logic [31:0] rd;
        int hi;
        bus_write(2'd1, 32'd4);
        bus_write(2'd0, 32'h0);
        bus_write(2'd2, 32'h81);
        hi = (out_port === 8'h81) ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            idle_check();
            if (out_port === 8'h81) hi++;
        end
        checks++;
        if (hi != 4 || out_port !== 8'h00) begin
            errors++;
            $display("FAIL pulse_len: got %0d cycles of 81 (final %h) expected 4 cycles then 00", hi, out_port);
        end
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h2) begin
            errors++;
            $display("FAIL pulse_status: got %h expected 00000002", rd);
        end
    endtask

    task automatic test_busy_boundaries();
        bus_write(2'd1, 32'd10);
        bus_write(2'd2, 32'h3C);
        idle_check();
        idle_check();
        bus_write(2'd2, 32'hFF);
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'hF0);
        checks++;
        if (out_port !== 8'hCC) begin
            errors++;
            $display("FAIL data_during_pulse: got %h expected cc", out_port);
        end
        for (int i = 0; i < 6; i++) idle_check();
        checks++;
        if (out_port !== 8'hF0) begin
            errors++;
            $display("FAIL pulse_end_10: got %h expected f0", out_port);
        end
        // Retrigger attempt on the final pulse cycle must be dropped.
        bus_write(2'd1, 32'd3);
        bus_write(2'd2, 32'h01);
        idle_check();
        idle_check();
        bus_write(2'd2, 32'h02);
        for (int i = 0; i < 3; i++) idle_check();
    endtask

    task automatic test_ignored();
        logic [31:0] rd;
        bus_write(2'd3, 32'h2);
        bus_write(2'd1, 32'd0);
        bus_write(2'd2, 32'h01);
        idle_check();
        bus_write(2'd1, 32'd3);
        bus_write(2'd2, 32'h00);
        idle_check();
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h0 || out_port !== m_data) begin
            errors++;
            $display("FAIL ignored_trig: status %h out_port %h expected 0 / %h", rd, out_port, m_data);
        end
    endtask

`ifdef SOPC_PIO_PULSE_IRQ_EN
    task automatic test_irq();
        bus_write(2'd3, 32'h6);
        bus_write(2'd1, 32'd2);
        bus_write(2'd2, 32'h01);
        idle_check();
        bus_write(2'd3, 32'h6);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set_wins: got %b expected 1", irq);
        end
        bus_write(2'd3, 32'h6);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear: got %b expected 0", irq);
        end
        bus_write(2'd3, 32'h0);
    endtask
`endif

    task automatic test_random();
        int op;
        for (int i = 0; i < 300; i++) begin
            op = int'($urandom_range(0, 6));
            case (op)
                0: bus_write(2'd0, $urandom);
                1: bus_write(2'd1, 32'($urandom_range(0, 6)));
                2: bus_write(2'd2, ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
                3: bus_write(2'd3, $urandom & 32'h6);
                default: idle_check();
            endcase
        end
        for (int i = 0; i < 8; i++) idle_check();
    endtask

    task automatic test_reset_mid_pulse();
        bus_write(2'd1, 32'h0000_FFFF);
        bus_write(2'd0, 32'h00);
        bus_write(2'd2, 32'hA5);
        for (int i = 0; i < 300; i++) idle_check();
        hold_reset(3);
        for (int i = 0; i < 6; i++) idle_check();
        checks++;
        if (out_port !== 8'h5A || readdata !== 32'h0) begin
            errors++;
            $display("FAIL post_reset: out_port %h status %h expected 5a / 0", out_port, readdata);
        end
    endtask

    initial begin
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 32'h0;
        model_reset();
        test_reset();
        test_data();
        test_pulse();
        test_busy_boundaries();
        test_ignored();
`ifdef SOPC_PIO_PULSE_IRQ_EN
        test_irq();
`endif
        test_random();
        test_reset_mid_pulse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
